// File: rtl/dtm_dmi_ctrl_pkg.sv
// Shared DMI types for the debug transport module and the debug module.
// Request/response bundles, op/status encodings and fixed DTM constants.
package DM;

    localparam int DMI_ABITS   = 7;
    localparam int DTM_VERSION = 1;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'd0,
        DTM_READ  = 2'd1,
        DTM_WRITE = 2'd2,
        DTM_RSVD  = 2'd3
    } dtm_op_e;

    typedef enum logic [1:0] {
        DMI_SUCCESS = 2'd0,
        DMI_FAILED  = 2'd2,
        DMI_BUSY    = 2'd3
    } dmi_stat_e;

    typedef struct packed {
        logic [DMI_ABITS-1:0] addr;
        dtm_op_e              op;
        logic [31:0]          data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

// File: rtl/dtm_dmi_ctrl_if.sv
// DMI request/response handshake between the DTM and the debug module.
// master = DTM side, slave = debug module side.
interface dtm_dmi_ctrl_if;
    import DM::*;

    logic      dmi_req_valid_o;
    logic      dmi_req_ready_i;
    dmi_req_t  dmi_req_o;
    logic      dmi_resp_valid_i;
    logic      dmi_resp_ready_o;
    dmi_resp_t dmi_resp_i;

    modport master (
        output dmi_req_valid_o,
        output dmi_req_o,
        output dmi_resp_ready_o,
        input  dmi_req_ready_i,
        input  dmi_resp_valid_i,
        input  dmi_resp_i
    );

    modport slave (
        input  dmi_req_valid_o,
        input  dmi_req_o,
        input  dmi_resp_ready_o,
        output dmi_req_ready_i,
        output dmi_resp_valid_i,
        output dmi_resp_i
    );

endinterface

// File: rtl/dtm_dmi_ctrl.sv
// DMI-side controller of the JTAG DTM: turns TAP DMI updates into DM
// requests, collects responses and keeps the sticky dmistat.
module dtm_dmi_ctrl
    import DM::*;
#(
    parameter int AddrBits   = DMI_ABITS,
    parameter int IdleCycles = 1,
    parameter int Version    = DTM_VERSION
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           update_dmi_i,
    input  logic           capture_dmi_i,
    input  logic [40:0]    dmi_shift_i,
    input  logic           dmireset_i,
    input  logic           dmihardreset_i,
    output logic [40:0]    dmi_capture_o,
    output logic [31:0]    dtmcs_o,
    dtm_dmi_ctrl_if.master dmi
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_e;

    state_e              state;
    logic [AddrBits-1:0] addr_q;
    logic [31:0]         data_q;
    logic [1:0]          stat;
    logic [1:0]          stat_nxt;
    dmi_req_t            req_q;
    logic                req_valid_q;
    logic                resp_ready_q;
    logic [40:0]         cap_q;
    dtm_op_e             new_op;
    logic                start;
    logic                busy;
    logic                resp_hs;
    logic                resp_err;

    assign new_op   = dtm_op_e'(dmi_shift_i[1:0]);
    assign start    = (state == S_IDLE) && update_dmi_i && (stat == 2'd0)
                      && (new_op == DTM_READ || new_op == DTM_WRITE);
    assign busy     = (state != S_IDLE) && (update_dmi_i || capture_dmi_i);
    assign resp_hs  = (state == S_RESP) && dmi.dmi_resp_valid_i;
    assign resp_err = resp_hs && (dmi.dmi_resp_i.resp == DMI_FAILED
                               || dmi.dmi_resp_i.resp == DMI_BUSY);

    // First error wins; a clearing request overrides any error this cycle.
    always_comb begin
        stat_nxt = stat;
        if (resp_err && stat_nxt == 2'd0) stat_nxt = dmi.dmi_resp_i.resp;
        if (busy && stat_nxt == 2'd0) stat_nxt = DMI_BUSY;
        if (dmireset_i || dmihardreset_i) stat_nxt = 2'd0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            stat         <= 2'd0;
            req_q        <= '0;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b1;
            cap_q        <= '0;
        end else begin
            stat <= stat_nxt;
            if (capture_dmi_i)
                cap_q <= {addr_q, data_q,
                          (state == S_IDLE) ? stat : 2'(DMI_BUSY)};
            if (dmihardreset_i) begin
                state        <= S_IDLE;
                req_valid_q  <= 1'b0;
                resp_ready_q <= 1'b1;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            state        <= S_REQ;
                            req_valid_q  <= 1'b1;
                            resp_ready_q <= 1'b0;
                            addr_q       <= dmi_shift_i[34 +: AddrBits];
                            req_q.addr   <= dmi_shift_i[40:34];
                            req_q.data   <= dmi_shift_i[33:2];
                            req_q.op     <= new_op;
                        end
                    end
                    S_REQ: begin
                        if (dmi.dmi_req_ready_i) begin
                            state        <= S_RESP;
                            req_valid_q  <= 1'b0;
                            resp_ready_q <= 1'b1;
                        end
                    end
                    S_RESP: begin
                        if (resp_hs) begin
                            state <= S_IDLE;
                            if (req_q.op == DTM_READ)
                                data_q <= dmi.dmi_resp_i.data;
                        end
                    end
                    default: begin
                        state        <= S_IDLE;
                        req_valid_q  <= 1'b0;
                        resp_ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign dmi.dmi_req_valid_o  = req_valid_q;
    assign dmi.dmi_req_o        = req_q;
    assign dmi.dmi_resp_ready_o = resp_ready_q;
    assign dmi_capture_o        = cap_q;
    assign dtmcs_o = {17'b0, 3'(IdleCycles), stat, 6'(AddrBits), 4'(Version)};

endmodule

// File: tb/tb_dtm_dmi_ctrl.sv
// Bench for dtm_dmi_ctrl: directed scenarios then random traffic against
// a transaction-level model of the DTM and a simple DM memory.
module tb_dtm_dmi_ctrl;
    import DM::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, upd, cap, dr, dhr;
    logic [40:0] shift;
    logic [40:0] capo;
    logic [31:0] dtmcs;

    dtm_dmi_ctrl_if bus();

    dtm_dmi_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .update_dmi_i   (upd),
        .capture_dmi_i  (cap),
        .dmi_shift_i    (shift),
        .dmireset_i     (dr),
        .dmihardreset_i (dhr),
        .dmi_capture_o  (capo),
        .dtmcs_o        (dtmcs),
        .dmi            (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: m_ph 0 = nothing pending, 1 = offered to DM, 2 = awaiting reply
    int          m_ph;
    logic [6:0]  m_addr, r_addr;
    logic [1:0]  r_op, m_stat;
    logic [31:0] m_data, r_data;
    logic [40:0] m_cap;

    logic [31:0] mem [128];
    logic        owe;
    int          cnt;
    logic [31:0] odata;
    logic [1:0]  ocode;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [40:0] w(input logic [6:0] a,
                                      input logic [31:0] d,
                                      input logic [1:0] o);
        return {a, d, o};
    endfunction

    function automatic logic [31:0] dtmcs_exp(input logic [1:0] s);
        return {17'b0, 3'd1, s, 6'd7, 4'd1};
    endfunction

    task automatic model();
        int ph;
        logic [1:0] st, op;
        if (rst) begin
            m_ph = 0; m_addr = '0; m_data = '0; m_stat = '0; m_cap = '0;
            return;
        end
        if (cap) m_cap = {m_addr, m_data, (m_ph == 0) ? m_stat : 2'd3};
        op = shift[1:0];
        st = m_stat;
        ph = m_ph;
        if (dhr) begin
            ph = 0;
            st = 2'd0;
        end else begin
            if (m_ph == 0 && upd && (op == 2'd1 || op == 2'd2) && m_stat == 0) begin
                ph = 1;
                r_addr = shift[40:34]; r_data = shift[33:2]; r_op = op;
                m_addr = shift[40:34];
            end
            if (m_ph == 1 && bus.dmi_req_ready_i) ph = 2;
            if (m_ph == 2 && bus.dmi_resp_valid_i) begin
                ph = 0;
                if (r_op == 2'd1) m_data = bus.dmi_resp_i.data;
                if (bus.dmi_resp_i.resp >= 2 && st == 0) st = bus.dmi_resp_i.resp;
            end
            if (m_ph != 0 && (upd || cap) && st == 0) st = 2'd3;
            if (dr) st = 2'd0;
        end
        m_ph = ph;
        m_stat = st;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 64'(bus.dmi_req_valid_o), 64'(m_ph == 1));
        if (m_ph == 1)
            chk({tag, ".req"}, 64'(bus.dmi_req_o), 64'({r_addr, r_op, r_data}));
        chk({tag, ".rrdy"}, 64'(bus.dmi_resp_ready_o), 64'(m_ph != 1));
        chk({tag, ".cap"}, 64'(capo), 64'(m_cap));
        chk({tag, ".dtmcs"}, 64'(dtmcs), 64'(dtmcs_exp(m_stat)));
    endtask

    task automatic cyc(input string tag, input logic u, input logic c,
                       input logic [40:0] sh, input logic r, input logic h,
                       input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic [1:0] rc, input logic rs);
        upd = u; cap = c; shift = sh; dr = r; dhr = h; rst = rs;
        bus.dmi_req_ready_i  = rdy;
        bus.dmi_resp_valid_i = rv;
        bus.dmi_resp_i       = {rd, rc};
        model();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, '0, 0, 0, 0, 0, '0, 2'd0, 0);
    endtask

    initial begin
        upd = 0; cap = 0; shift = '0; dr = 0; dhr = 0; rst = 1;
        bus.dmi_req_ready_i = 0; bus.dmi_resp_valid_i = 0; bus.dmi_resp_i = '0;
        m_ph = 0; m_addr = '0; m_data = '0; m_stat = '0; m_cap = '0;
        r_addr = '0; r_op = '0; r_data = '0;
        owe = 0; cnt = 0; odata = '0; ocode = '0;
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        @(negedge clk);

        cyc("rst", 0, 0, '0, 0, 0, 0, 0, '0, 2'd0, 1);
        chk("rst_valid", 64'(bus.dmi_req_valid_o), 64'd0);
        chk("rst_rrdy", 64'(bus.dmi_resp_ready_o), 64'd1);
        chk("rst_cap", 64'(capo), 64'd0);
        chk("rst_dtmcs", 64'(dtmcs), 64'h1071);

        // Read
        cyc("rd0", 1, 0, w(7'h11, 0, 2'd1), 0, 0, 0, 0, '0, 2'd0, 0);
        chk("rd_addr", 64'(bus.dmi_req_o.addr), 64'h11);
        chk("rd_op", 64'(bus.dmi_req_o.op), 64'd1);
        cyc("rd1", 0, 0, '0, 0, 0, 1, 0, '0, 2'd0, 0);
        idle("rd2");
        cyc("rd3", 0, 0, '0, 0, 0, 0, 1, 32'h0000_0C00, 2'd0, 0);
        cyc("rd4", 0, 1, '0, 0, 0, 0, 0, '0, 2'd0, 0);
        chk("rd_cap", 64'(capo), 64'({7'h11, 32'h0000_0C00, 2'b00}));

        // Write with a 5-cycle stall
        cyc("wr0", 1, 0, w(7'h10, 32'h1, 2'd2), 0, 0, 0, 0, '0, 2'd0, 0);
        for (int i = 0; i < 5; i++) begin
            chk("wr_hold_v", 64'(bus.dmi_req_valid_o), 64'd1);
            chk("wr_hold_p", 64'(bus.dmi_req_o), 64'({7'h10, 2'd2, 32'h1}));
            if (i < 4) idle("wrs");
        end
        cyc("wr1", 0, 0, '0, 0, 0, 1, 0, '0, 2'd0, 0);
        chk("wr_once", 64'(bus.dmi_req_valid_o), 64'd0);
        cyc("wr2", 0, 0, '0, 0, 0, 0, 1, 32'hFFFF_FFFF, 2'd0, 0);
        cyc("wr3", 0, 1, '0, 0, 0, 0, 0, '0, 2'd0, 0);
        chk("wr_cap", 64'(capo), 64'({7'h10, 32'h0000_0C00, 2'b00}));

        // Busy
        cyc("bz0", 1, 0, w(7'h05, 0, 2'd1), 0, 0, 0, 0, '0, 2'd0, 0);
        cyc("bz1", 0, 0, '0, 0, 0, 1, 0, '0, 2'd0, 0);
        cyc("bz2", 1, 0, w(7'h09, 0, 2'd1), 0, 0, 0, 0, '0, 2'd0, 0);
        chk("bz_stat", 64'(dtmcs[11:10]), 64'd3);
        cyc("bz3", 0, 0, '0, 0, 0, 0, 1, 32'h0000_1234, 2'd0, 0);
        cyc("bz4", 1, 0, w(7'h09, 0, 2'd1), 0, 0, 0, 0, '0, 2'd0, 0);
        chk("bz_ignored", 64'(bus.dmi_req_valid_o), 64'd0);
        cyc("bz5", 0, 0, '0, 1, 0, 0, 0, '0, 2'd0, 0);
        chk("bz_clear", 64'(dtmcs[11:10]), 64'd0);
        cyc("bz6", 1, 0, w(7'h06, 32'hAB, 2'd2), 0, 0, 0, 0, '0, 2'd0, 0);
        chk("bz_reissue", 64'(bus.dmi_req_valid_o), 64'd1);
        cyc("bz7", 0, 0, '0, 0, 0, 1, 0, '0, 2'd0, 0);
        cyc("bz8", 0, 0, '0, 0, 0, 0, 1, '0, 2'd0, 0);

        // Failed response with a same-cycle busy event
        cyc("fl0", 1, 0, w(7'h03, 32'h55, 2'd2), 0, 0, 0, 0, '0, 2'd0, 0);
        cyc("fl1", 0, 0, '0, 0, 0, 1, 0, '0, 2'd0, 0);
        cyc("fl2", 1, 0, w(7'h04, 0, 2'd1), 0, 0, 0, 1, '0, 2'd2, 0);
        chk("fl_dtmcs", 64'(dtmcs), 64'h1871);
        chk("fl_abits", 64'(dtmcs[9:4]), 64'd7);

        // Hard reset while a request is offered
        cyc("hr0", 0, 0, '0, 1, 0, 0, 0, '0, 2'd0, 0);
        cyc("hr1", 1, 0, w(7'h22, 0, 2'd1), 0, 0, 0, 0, '0, 2'd0, 0);
        chk("hr_valid", 64'(bus.dmi_req_valid_o), 64'd1);
        cyc("hr2", 0, 0, '0, 0, 1, 0, 0, '0, 2'd0, 0);
        chk("hr_drop", 64'(bus.dmi_req_valid_o), 64'd0);
        cyc("hr3", 0, 0, '0, 0, 0, 0, 1, 32'hDEAD_BEEF, 2'd3, 0);
        cyc("hr4", 0, 1, '0, 0, 0, 0, 0, '0, 2'd0, 0);
        chk("hr_cap", 64'(capo), 64'({7'h22, 32'h0000_1234, 2'b00}));

        // Reset while waiting for a response
        cyc("rr0", 1, 0, w(7'h01, 0, 2'd1), 0, 0, 0, 0, '0, 2'd0, 0);
        cyc("rr1", 0, 0, '0, 0, 0, 1, 0, '0, 2'd0, 0);
        cyc("rr2", 0, 0, '0, 0, 0, 0, 0, '0, 2'd0, 1);
        chk("rr_valid", 64'(bus.dmi_req_valid_o), 64'd0);
        chk("rr_rrdy", 64'(bus.dmi_resp_ready_o), 64'd1);
        chk("rr_cap", 64'(capo), 64'd0);
        idle("rr3");

        // Random traffic against a DM memory with variable latency
        for (int i = 0; i < 3000; i++) begin
            logic u, c, r, h, rdy, rv, rs, hs_now, take_now;
            logic [40:0] sh;
            logic [6:0]  sa;
            logic [1:0]  sop;
            logic [31:0] sd;
            int          k;
            rv  = owe && cnt == 0;
            rdy = !owe && ($urandom_range(0, 2) != 0);
            u   = ($urandom_range(0, 3) == 0) && !(m_ph == 0 && owe);
            c   = ($urandom_range(0, 4) == 0);
            r   = ($urandom_range(0, 29) == 0);
            h   = ($urandom_range(0, 49) == 0);
            rs  = ($urandom_range(0, 199) == 0);
            sh  = {7'($urandom_range(0, 7)), 32'($urandom),
                   2'($urandom_range(0, 3))};
            hs_now   = (m_ph == 1) && rdy;
            take_now = rv && (m_ph != 1);
            sa = r_addr; sop = r_op; sd = r_data;
            cyc("rnd", u, c, sh, r, h, rdy, rv, odata, ocode, rs);
            if (take_now) owe = 0;
            else if (owe && cnt > 0) cnt--;
            if (hs_now) begin
                owe = 1;
                cnt = $urandom_range(0, 3);
                k = $urandom_range(0, 9);
                ocode = (k == 0) ? 2'd2 : (k == 1) ? 2'd3 : 2'd0;
                odata = (sop == 2'd1) ? mem[sa] : $urandom;
                if (sop == 2'd2) mem[sa] = sd;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
